ptpv2_pps_capture: RTL and testbench
====================================

// Module: ptpv2_pps_capture
// PURPOSE
// - Receive side of the 1PPS interface: the core emits pps_o; this block accepts an external pps_i and timestamps it.
// - Synchronises pps_i into the RTC domain, glitch-filters it and captures the RTC {sec,ns} at each qualified rising edge.
// - Presents the capture to software through a valid/ack handshake and flags overrun and missing pulses.
// - Sits beside the RTC in ptpv2_core_wrapper; its interrupt is OR-ed into intxms_o by the wrapper.
// PARAMETERS
// - SYNC_STAGES     2          synchroniser flops on pps_i, min 2
// - MIN_HIGH_CYC    4          cycles pps must stay high after edge detect to qualify, min 1
// - MISS_TMO_CYC    150000000  cycles without a qualified pulse before miss_o fires (1.2 s at 8 ns)
// - LAT_NS          24         ns subtracted by the latency-compensation option, must be < 1e9
// PORTS
// - rtc_clk      in   1   RTC clock, sole clock
// - rtc_rst_n    in   1   asynchronous reset, active low
// - enable_i     in   1   block enable, level
// - pps_i        in   1   external PPS, asynchronous
// - rtc_sec_i    in   48  RTC seconds, rtc_clk domain
// - rtc_ns_i     in   30  RTC nanoseconds, 0..999999999
// - cap_ack_i    in   1   one-cycle software acknowledge of the current capture
// - cap_valid_o  out  1   capture registers hold an unacknowledged timestamp
// - cap_sec_o    out  48  captured seconds
// - cap_ns_o     out  30  captured nanoseconds
// - cap_ovf_o    out  1   sticky: a qualified pulse arrived while cap_valid_o=1 and no ack
// - glitch_o     out  1   one-cycle pulse: an edge was rejected by the filter
// - miss_o       out  1   one-cycle pulse: miss timeout expired
// - int_pps_o    out  1   cap_valid_o | cap_ovf_o
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, synchroniser, pending regs and miss timer cleared.
// - Edge detect: rise = sync_out & ~sync_prev; first possible at rtc_clk edge SYNC_STAGES after pps_i rises.
// - On rise in WAIT_RISE, {rtc_sec_i, rtc_ns_i} at that edge is latched into pending regs.
// - FSM:
//   IDLE:      enable_i=1 -> WAIT_RISE.
//   WAIT_RISE: rise -> QUAL, hcnt=1.
//   QUAL:      sync_out=1 -> hcnt++; hcnt==MIN_HIGH_CYC -> COMMIT. sync_out=0 first -> glitch_o=1, pending dropped, -> WAIT_RISE.
//   COMMIT:    single cycle, loads the capture registers, -> WAIT_LOW.
//   WAIT_LOW:  sync_out=0 -> WAIT_RISE. A held-high input never re-captures.
// - cap_valid_o rises MIN_HIGH_CYC+1 cycles after the rise cycle.
// - Handshake:
//   - cap_ack_i with cap_valid_o=1 clears cap_valid_o and cap_ovf_o next cycle.
//   - cap_ack_i with cap_valid_o=0 is ignored.
//   - COMMIT with cap_valid_o=0: load data, set valid.
//   - COMMIT with valid=1 and no ack: keep old data, set cap_ovf_o.
//   - COMMIT and ack in the same cycle: load new data, valid stays 1, ovf cleared.
// - Miss timer: cleared in IDLE and at COMMIT, else increments. At MISS_TMO_CYC-1 it pulses miss_o and wraps to 0; it repeats each timeout.
// - enable_i=0 from any state -> IDLE next cycle; pending and timer cleared; capture outputs and handshake keep working.
// - Reset mid-pulse: the pulse is lost; the next edge is seen only after sync_out returns low, then high.
// CONFIGURATION
// - PPS_LATENCY_COMP_EN defined:
//   - At COMMIT, ns' = ns-LAT_NS and sec' = sec.
//   - If ns<LAT_NS: ns' = ns+1000000000-LAT_NS, sec' = sec-1 (48-bit wrap at 0).
//   - Adder is registered in the pending stage, so there is no extra latency.
// - Not defined: raw latched values are committed unchanged.
// TESTING
// - pps_i high 20 cycles, rtc={5,1000} at rise cycle -> cap_valid_o at rise+5, cap={5,1000} (comp off) / {5,976} (comp on).
// - Comp on, rtc={7,10} at rise -> cap={6,999999986}.
// - pps_i high 2 cycles -> glitch_o pulse, cap_valid_o stays 0, next clean pulse captured.
// - Two pulses, no ack -> first timestamp kept, cap_ovf_o=1. Ack -> valid=0, ovf=0.
// - MISS_TMO_CYC=100, no pps -> miss_o at cycles 100 and 200 after enable. Pulse at 150 -> next miss 100 cycles after its COMMIT.
// - enable_i dropped during QUAL -> IDLE, no capture. Async reset mid-WAIT_LOW -> all outputs 0 immediately.

Source files
------------

// File: rtl/ptpv2_pps_capture.sv
// ptpv2_pps_capture
// Receive side of the 1PPS interface. An external, asynchronous pps_i is
// synchronised into the RTC domain and glitch-filtered. At each qualified
// rising edge the RTC {sec,ns} is captured and handed to software through
// a valid/ack handshake. Overrun and missing-pulse conditions are flagged.
//
// Optional feature macro: PPS_LATENCY_COMP_EN
//   defined   : LAT_NS is subtracted from the captured time (borrowing a
//               second when ns < LAT_NS); the subtraction is done when the
//               pending registers load, so it adds no latency.
//   undefined : the raw RTC value is committed unchanged.
//
// Ports
//   rtc_clk, rtc_rst_n      sole clock, async active-low reset
//   enable_i                block enable (level)
//   pps_i                   external PPS, asynchronous
//   rtc_sec_i, rtc_ns_i     free-running RTC time, rtc_clk domain
//   cap_ack_i               one-cycle acknowledge of the current capture
//   cap_valid_o             capture registers hold an unacknowledged stamp
//   cap_sec_o, cap_ns_o     captured time
//   cap_ovf_o               sticky: pulse qualified while capture unacked
//   glitch_o                one-cycle: an edge was rejected by the filter
//   miss_o                  one-cycle: no qualified pulse within timeout
//   int_pps_o               cap_valid_o | cap_ovf_o
module ptpv2_pps_capture #(
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_HIGH_CYC = 4,
    parameter int MISS_TMO_CYC = 150000000,
    parameter int LAT_NS       = 24
) (
    input  logic        rtc_clk,
    input  logic        rtc_rst_n,
    input  logic        enable_i,
    input  logic        pps_i,
    input  logic [47:0] rtc_sec_i,
    input  logic [29:0] rtc_ns_i,
    input  logic        cap_ack_i,
    output logic        cap_valid_o,
    output logic [47:0] cap_sec_o,
    output logic [29:0] cap_ns_o,
    output logic        cap_ovf_o,
    output logic        glitch_o,
    output logic        miss_o,
    output logic        int_pps_o
);

`ifdef PPS_LATENCY_COMP_EN
    localparam bit COMP_EN = 1'b1;
`else
    localparam bit COMP_EN = 1'b0;
`endif

    localparam int HW = $clog2(MIN_HIGH_CYC + 1);
    localparam int TW = $clog2(MISS_TMO_CYC + 1);

    localparam logic [HW-1:0] HCNT_LAST = HW'(MIN_HIGH_CYC - 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(MISS_TMO_CYC - 1);
    localparam logic [29:0]   LAT       = 30'(LAT_NS);
    localparam logic [29:0]   NS_BORROW = 30'd1000000000 - LAT;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_RISE = 3'd1;
    localparam logic [2:0] S_QUAL      = 3'd2;
    localparam logic [2:0] S_COMMIT    = 3'd3;
    localparam logic [2:0] S_WAIT_LOW  = 3'd4;

    // ---------------- synchroniser / edge detect ----------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] primed_q, primed_d;
    logic                   sync_prev_q, sync_prev_d;
    logic                   armed_q, armed_d;
    logic                   sync_out, rise;

    // primed_q marks when the cleared synchroniser has been refilled from
    // pps_i. Only a low seen after that arms the edge detector, so a pulse
    // already high across reset is ignored until it goes low and high again.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], pps_i};
        primed_d    = {primed_q[SYNC_STAGES-2:0], 1'b1};
        sync_out    = sync_q[SYNC_STAGES-1];
        sync_prev_d = sync_out;
        armed_d     = armed_q | (primed_q[SYNC_STAGES-1] & ~sync_out);
        rise        = sync_out & ~sync_prev_q & armed_q;
    end

    // ---------------- FSM, pending stamp, miss timer ----------------
    logic [2:0]    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [47:0]   pend_sec_q, pend_sec_d;
    logic [29:0]   pend_ns_q, pend_ns_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          commit, glitch, miss;
    logic [47:0]   in_sec;
    logic [29:0]   in_ns;

    // Latency compensation is folded into the pending load.
    always_comb begin
        in_sec = rtc_sec_i;
        in_ns  = rtc_ns_i;
        if (COMP_EN) begin
            if (rtc_ns_i < LAT) begin
                in_sec = rtc_sec_i - 48'd1;
                in_ns  = rtc_ns_i + NS_BORROW;
            end else begin
                in_ns  = rtc_ns_i - LAT;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        pend_sec_d = pend_sec_q;
        pend_ns_d  = pend_ns_q;
        commit     = 1'b0;
        glitch     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (rise) begin
                    pend_sec_d = in_sec;
                    pend_ns_d  = in_ns;
                    hcnt_d     = HW'(1);
                    // The rise cycle itself counts as the first high cycle.
                    state_d    = (MIN_HIGH_CYC <= 1) ? S_COMMIT : S_QUAL;
                end
            end
            S_QUAL: begin
                if (!sync_out) begin
                    glitch     = 1'b1;
                    pend_sec_d = '0;
                    pend_ns_d  = '0;
                    hcnt_d     = '0;
                    state_d    = S_WAIT_RISE;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                    if (hcnt_q == HCNT_LAST) state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                hcnt_d  = '0;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!sync_out) state_d = S_WAIT_RISE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable_i) begin
            state_d    = S_IDLE;
            hcnt_d     = '0;
            pend_sec_d = '0;
            pend_ns_d  = '0;
            commit     = 1'b0;
            glitch     = 1'b0;
        end
    end

    // Miss timer runs whenever the block is armed and restarts on each
    // commit; it wraps on expiry so miss_o repeats every timeout.
    always_comb begin
        miss  = 1'b0;
        tmr_d = tmr_q + TW'(1);
        if (!enable_i || state_q == S_IDLE || commit) begin
            tmr_d = '0;
        end else if (tmr_q == TMR_LAST) begin
            tmr_d = '0;
            miss  = 1'b1;
        end
    end

    // ---------------- capture registers / handshake ----------------
    logic        cap_valid_q, cap_valid_d;
    logic        cap_ovf_q, cap_ovf_d;
    logic [47:0] cap_sec_q, cap_sec_d;
    logic [29:0] cap_ns_q, cap_ns_d;
    logic        ack;

    always_comb begin
        ack         = cap_ack_i & cap_valid_q;
        cap_valid_d = cap_valid_q;
        cap_ovf_d   = cap_ovf_q;
        cap_sec_d   = cap_sec_q;
        cap_ns_d    = cap_ns_q;
        if (commit && (!cap_valid_q || ack)) begin
            // Free slot, or the old stamp is being acked this very cycle.
            cap_valid_d = 1'b1;
            cap_ovf_d   = 1'b0;
            cap_sec_d   = pend_sec_q;
            cap_ns_d    = pend_ns_q;
        end else if (commit) begin
            // Software has not taken the old stamp: keep it, flag overrun.
            cap_ovf_d = 1'b1;
        end else if (ack) begin
            cap_valid_d = 1'b0;
            cap_ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            sync_q      <= '0;
            primed_q    <= '0;
            sync_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            hcnt_q      <= '0;
            pend_sec_q  <= '0;
            pend_ns_q   <= '0;
            tmr_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_ovf_q   <= 1'b0;
            cap_sec_q   <= '0;
            cap_ns_q    <= '0;
        end else begin
            sync_q      <= sync_d;
            primed_q    <= primed_d;
            sync_prev_q <= sync_prev_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            pend_sec_q  <= pend_sec_d;
            pend_ns_q   <= pend_ns_d;
            tmr_q       <= tmr_d;
            cap_valid_q <= cap_valid_d;
            cap_ovf_q   <= cap_ovf_d;
            cap_sec_q   <= cap_sec_d;
            cap_ns_q    <= cap_ns_d;
        end
    end

    assign cap_valid_o = cap_valid_q;
    assign cap_ovf_o   = cap_ovf_q;
    assign cap_sec_o   = cap_sec_q;
    assign cap_ns_o    = cap_ns_q;
    assign glitch_o    = glitch;
    assign miss_o      = miss;
    assign int_pps_o   = cap_valid_q | cap_ovf_q;

endmodule

// File: tb/tb_ptpv2_pps_capture.sv
// Directed bench for ptpv2_pps_capture. Inputs are driven just after each
// falling edge and outputs sampled at the same point (mid-cycle). Expected
// capture values go to a scoreboard queue when a pulse is launched and are
// popped when cap_valid_o rises.
module tb_ptpv2_pps_capture;

    logic        rtc_clk;
    logic        rtc_rst_n;
    logic        enable_i;
    logic        pps_i;
    logic [47:0] rtc_sec_i;
    logic [29:0] rtc_ns_i;
    logic        cap_ack_i;
    logic        cap_valid_o;
    logic [47:0] cap_sec_o;
    logic [29:0] cap_ns_o;
    logic        cap_ovf_o;
    logic        glitch_o;
    logic        miss_o;
    logic        int_pps_o;

    int errors = 0;
    int checks = 0;
    logic [77:0] sb_q[$];

    ptpv2_pps_capture #(
        .SYNC_STAGES (2),
        .MIN_HIGH_CYC(4),
        .MISS_TMO_CYC(100),
        .LAT_NS      (24)
    ) dut (
        .rtc_clk    (rtc_clk),
        .rtc_rst_n  (rtc_rst_n),
        .enable_i   (enable_i),
        .pps_i      (pps_i),
        .rtc_sec_i  (rtc_sec_i),
        .rtc_ns_i   (rtc_ns_i),
        .cap_ack_i  (cap_ack_i),
        .cap_valid_o(cap_valid_o),
        .cap_sec_o  (cap_sec_o),
        .cap_ns_o   (cap_ns_o),
        .cap_ovf_o  (cap_ovf_o),
        .glitch_o   (glitch_o),
        .miss_o     (miss_o),
        .int_pps_o  (int_pps_o)
    );

    initial rtc_clk = 1'b0;
    always #4 rtc_clk = ~rtc_clk;

    task automatic tick();
        @(negedge rtc_clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected committed stamp for an RTC value sampled in the rise cycle.
    function automatic logic [77:0] exp_cap(input logic [47:0] s, input logic [29:0] n);
`ifdef PPS_LATENCY_COMP_EN
        if (n < 30'd24) return {s - 48'd1, n + 30'd1000000000 - 30'd24};
        return {s, n - 30'd24};
`else
        return {s, n};
`endif
    endfunction

    task automatic sb_check();
        logic [77:0] e;
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("cap_sec", 64'(cap_sec_o), 64'(e[77:30]));
            chk("cap_ns", 64'(cap_ns_o), 64'(e[29:0]));
        end
    endtask

    task automatic set_rtc(input logic [47:0] s, input logic [29:0] n, input bit push);
        rtc_sec_i = s;
        rtc_ns_i  = n;
        if (push) sb_q.push_back(exp_cap(s, n));
    endtask

    // Raise pps_i now; drop it after sample 'hi'. Ack / disable after the
    // given sample index (-1 = never). Reports the first valid-rise sample.
    task automatic run_pulse(input int hi, input int len, input int ack_at, input int dis_at,
                             output int vtick, output int nrise, output int gcnt);
        logic pv;
        vtick = -1;
        nrise = 0;
        gcnt  = 0;
        pv    = cap_valid_o;
        pps_i = 1'b1;
        for (int i = 1; i <= len; i++) begin
            tick();
            if (cap_valid_o && !pv) begin
                nrise++;
                if (vtick < 0) vtick = i;
                sb_check();
            end
            pv = cap_valid_o;
            if (glitch_o) gcnt++;
            if (i == hi) pps_i = 1'b0;
            cap_ack_i = (i == ack_at);
            if (i == dis_at) enable_i = 1'b0;
        end
        cap_ack_i = 1'b0;
    endtask

    task automatic do_ack();
        cap_ack_i = 1'b1;
        tick();
        cap_ack_i = 1'b0;
    endtask

    initial begin
        int vt, nr, gc;
        int mcnt, m1, m2, vrise;
        logic [77:0] ea;
        logic [77:0] ec;

        rtc_rst_n = 1'b0;
        enable_i  = 1'b0;
        pps_i     = 1'b0;
        cap_ack_i = 1'b0;
        rtc_sec_i = '0;
        rtc_ns_i  = '0;

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_valid", cap_valid_o, 0);
        chk("rst_sec", cap_sec_o, 0);
        chk("rst_ns", cap_ns_o, 0);
        chk("rst_ovf", cap_ovf_o, 0);
        chk("rst_glitch", glitch_o, 0);
        chk("rst_miss", miss_o, 0);
        chk("rst_int", int_pps_o, 0);
        rtc_rst_n = 1'b1;
        repeat (5) tick();

        // ---- miss timeout + clean capture {5,1000} launched at sample 150 ----
        set_rtc(48'd5, 30'd1000, 1'b1);
        enable_i = 1'b1;
        mcnt = 0; m1 = -1; m2 = -1; vrise = -1;
        for (int t = 1; t <= 300; t++) begin
            tick();
            if (miss_o) begin
                mcnt++;
                if (mcnt == 1) m1 = t;
                if (mcnt == 2) m2 = t;
            end
            if (cap_valid_o && vrise < 0) begin
                vrise = t;
                sb_check();
            end
            if (t == 150) pps_i = 1'b1;
            if (t == 170) pps_i = 1'b0;
        end
        chk("miss_first", m1, 100);
        chk("miss_after_commit", m2, 256);
        chk("miss_count", mcnt, 2);
        chk("valid_latency", vrise, 157);
        chk("int_on_valid", int_pps_o, 1);
        do_ack();
        chk("ack_clears_valid", cap_valid_o, 0);
        chk("ack_clears_int", int_pps_o, 0);
        do_ack();
        chk("ack_ignored_when_idle", cap_valid_o, 0);

        // ---- borrow case {7,10} ----
        set_rtc(48'd7, 30'd10, 1'b1);
        run_pulse(20, 30, -1, -1, vt, nr, gc);
        chk("borrow_vtick", vt, 7);
        chk("borrow_nrise", nr, 1);
        do_ack();

        // ---- glitch: 2-cycle pulse rejected, next clean pulse captured ----
        set_rtc(48'd99, 30'd99, 1'b0);
        run_pulse(2, 12, -1, -1, vt, nr, gc);
        chk("glitch_pulses", gc, 1);
        chk("glitch_no_capture", nr, 0);
        chk("glitch_valid_low", cap_valid_o, 0);
        set_rtc(48'd3, 30'd123456789, 1'b1);
        run_pulse(20, 30, -1, -1, vt, nr, gc);
        chk("after_glitch_vtick", vt, 7);
        chk("after_glitch_noglitch", gc, 0);
        do_ack();

        // ---- overrun: A kept, B dropped with ovf ----
        ea = exp_cap(48'd9, 30'd500);
        set_rtc(48'd9, 30'd500, 1'b1);
        run_pulse(20, 30, -1, -1, vt, nr, gc);
        chk("ovf_a_nrise", nr, 1);
        set_rtc(48'd10, 30'd600, 1'b0);
        run_pulse(20, 30, -1, -1, vt, nr, gc);
        chk("ovf_set", cap_ovf_o, 1);
        chk("ovf_valid_kept", cap_valid_o, 1);
        chk("ovf_int", int_pps_o, 1);
        chk("ovf_sec_kept", cap_sec_o, ea[77:30]);
        chk("ovf_ns_kept", cap_ns_o, ea[29:0]);

        // ---- ack in the COMMIT cycle: new data loaded, ovf cleared ----
        ec = exp_cap(48'd11, 30'd5);
        set_rtc(48'd11, 30'd5, 1'b0);
        run_pulse(20, 30, 6, -1, vt, nr, gc);
        chk("same_cyc_valid", cap_valid_o, 1);
        chk("same_cyc_ovf", cap_ovf_o, 0);
        chk("same_cyc_sec", cap_sec_o, ec[77:30]);
        chk("same_cyc_ns", cap_ns_o, ec[29:0]);
        do_ack();
        chk("ovf_ack_valid", cap_valid_o, 0);
        chk("ovf_ack_ovf", cap_ovf_o, 0);

        // ---- held-high input captures once only ----
        set_rtc(48'd12, 30'd777, 1'b1);
        run_pulse(999, 40, 10, -1, vt, nr, gc);
        chk("held_nrise", nr, 1);
        chk("held_valid_low", cap_valid_o, 0);
        pps_i = 1'b0;
        repeat (6) tick();

        // ---- enable dropped during QUAL ----
        set_rtc(48'd13, 30'd888, 1'b0);
        run_pulse(20, 30, -1, 3, vt, nr, gc);
        chk("dis_no_capture", nr, 0);
        chk("dis_no_glitch", gc, 0);
        chk("dis_valid_low", cap_valid_o, 0);
        enable_i = 1'b1;
        repeat (4) tick();

        // ---- async reset during WAIT_LOW ----
        set_rtc(48'd20, 30'd20000, 1'b1);
        run_pulse(999, 10, -1, -1, vt, nr, gc);
        chk("pre_rst_vtick", vt, 7);
        #2;
        rtc_rst_n = 1'b0;
        #1;
        chk("arst_valid", cap_valid_o, 0);
        chk("arst_sec", cap_sec_o, 0);
        chk("arst_ns", cap_ns_o, 0);
        chk("arst_int", int_pps_o, 0);
        tick();
        tick();
        rtc_rst_n = 1'b1;
        vrise = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (cap_valid_o) vrise++;
        end
        chk("lost_pulse_no_capture", vrise, 0);
        pps_i = 1'b0;
        repeat (5) tick();
        set_rtc(48'd0, 30'd3, 1'b1);
        run_pulse(20, 30, -1, -1, vt, nr, gc);
        chk("post_rst_vtick", vt, 7);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
